// File: rtl/hit_router_pkg.sv
// Shared types and defaults for the hit event router.
package hit_router_pkg;

  localparam int unsigned DEFAULT_NUM_OBJ = 4;
  localparam int unsigned DEFAULT_EDGE_W  = 4;

  typedef logic [$clog2(DEFAULT_NUM_OBJ)-1:0] obj_id_t;
  typedef logic [DEFAULT_EDGE_W-1:0]          edge_t;

  typedef enum logic [0:0] {
    COLLECT,
    REPORT
  } state_t;

endpackage

// File: rtl/hit_priority_pick.sv
// Lowest-set-index finder: idx is the lowest asserted bit of req, any flags a non-empty req.
module hit_priority_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  output logic [IdW-1:0] idx,
  output logic           any
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IdW'(i);
    end
  end

endmodule

// File: rtl/hit_event_router.sv
// Collision accumulator and per-frame event dispatcher.
// Optional HIT_OVERRUN_CNT_EN adds an 8-bit saturating count of discarded events.
module hit_event_router
  import hit_router_pkg::*;
#(
  parameter int unsigned NUM_OBJ = DEFAULT_NUM_OBJ,
  parameter int unsigned EDGE_W  = DEFAULT_EDGE_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic                        playerDrawingRequest,
  input  logic [NUM_OBJ-1:0]          objDrawingRequest,
  input  logic [NUM_OBJ*EDGE_W-1:0]   objHitEdgeCode,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_OBJ)-1:0]  evt_id,
  output logic [EDGE_W-1:0]           evt_edge,
  output logic                        overrun,
`ifdef HIT_OVERRUN_CNT_EN
  output logic [7:0]                  overrun_cnt,
`endif
  output logic                        frame_busy
);

  localparam int unsigned IdW  = $clog2(NUM_OBJ);

  logic [NUM_OBJ-1:0]        pix_hit;
  logic [NUM_OBJ*EDGE_W-1:0] pix_edge;
  logic [NUM_OBJ-1:0]        acc_hit_q, acc_hit_d;
  logic [NUM_OBJ*EDGE_W-1:0] acc_edge_q, acc_edge_d;
  logic [NUM_OBJ-1:0]        rep_hit_q, rep_hit_d, pending;
  logic [NUM_OBJ*EDGE_W-1:0] rep_edge_q, rep_edge_d;
  logic                      accept;
  logic                      drop;
  logic [IdW-1:0]            pick_id;
  logic                      pick_any;
  logic [EDGE_W-1:0]         pick_edge;
  state_t                    state;

  // Current-pixel hits: an object counts only where the player also draws.
  always_comb begin
    pix_hit  = '0;
    pix_edge = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      pix_hit[i] = playerDrawingRequest & objDrawingRequest[i];
      if (pix_hit[i]) pix_edge[i*EDGE_W +: EDGE_W] = objHitEdgeCode[i*EDGE_W +: EDGE_W];
    end
  end

  // Accumulator next state; the boundary pixel starts the new frame.
  always_comb begin
    if (startOfFrame) begin
      acc_hit_d  = pix_hit;
      acc_edge_d = pix_edge;
    end else begin
      acc_hit_d  = acc_hit_q | pix_hit;
      acc_edge_d = acc_edge_q | pix_edge;
    end
  end

  // Snapshot next state: retire the accepted event, or replace everything at a frame boundary.
  always_comb begin
    accept  = evt_valid & evt_ready;
    pending = rep_hit_q;
    if (accept) pending[evt_id] = 1'b0;
    drop = startOfFrame & (|pending);
    if (startOfFrame) begin
      rep_hit_d  = acc_hit_q;
      rep_edge_d = acc_edge_q;
    end else begin
      rep_hit_d  = pending;
      rep_edge_d = rep_edge_q;
    end
    pick_edge = rep_edge_d[pick_id*EDGE_W +: EDGE_W];
  end

  hit_priority_pick #(
    .N   (NUM_OBJ),
    .IdW (IdW)
  ) u_pick (
    .req (rep_hit_d),
    .idx (pick_id),
    .any (pick_any)
  );

`ifdef HIT_OVERRUN_CNT_EN
  localparam int unsigned CntW = $clog2(NUM_OBJ + 1);
  logic [CntW-1:0] drop_cnt;
  logic [8:0]      cnt_sum;

  // Number of events thrown away by this boundary, added with saturation.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_OBJ; i++) drop_cnt = drop_cnt + CntW'(pending[i]);
    cnt_sum = {1'b0, overrun_cnt} + 9'(drop_cnt);
  end

  // Saturating overrun event counter.
  always_ff @(posedge clk) begin
    if (reset) overrun_cnt <= '0;
    else if (drop) overrun_cnt <= cnt_sum[8] ? 8'hff : cnt_sum[7:0];
  end
`endif

  // FSM with registered outputs; the event presented is always the lowest pending index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      acc_hit_q  <= '0;
      acc_edge_q <= '0;
      rep_hit_q  <= '0;
      rep_edge_q <= '0;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_edge   <= '0;
      overrun    <= 1'b0;
      frame_busy <= 1'b0;
    end else begin
      acc_hit_q  <= acc_hit_d;
      acc_edge_q <= acc_edge_d;
      rep_hit_q  <= rep_hit_d;
      rep_edge_q <= rep_edge_d;
      evt_valid  <= pick_any;
      evt_id     <= pick_id;
      evt_edge   <= pick_any ? pick_edge : '0;
      if (drop) overrun <= 1'b1;
      unique case (state)
        COLLECT: begin
          if (startOfFrame && pick_any) begin
            state      <= REPORT;
            frame_busy <= 1'b1;
          end
        end
        REPORT: begin
          if (!pick_any) begin
            state      <= COLLECT;
            frame_busy <= 1'b0;
          end
        end
        default: begin
          state      <= COLLECT;
          frame_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_event_router.sv
// Directed self-checking bench for hit_event_router (optionally with HIT_OVERRUN_CNT_EN).
module tb_hit_event_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        playerDrawingRequest;
  logic [3:0]  objDrawingRequest;
  logic [15:0] objHitEdgeCode;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_id;
  logic [3:0]  evt_edge;
  logic        overrun;
  logic        frame_busy;
`ifdef HIT_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hit_event_router dut (
    .clk                  (clk),
    .reset                (reset),
    .startOfFrame         (startOfFrame),
    .playerDrawingRequest (playerDrawingRequest),
    .objDrawingRequest    (objDrawingRequest),
    .objHitEdgeCode       (objHitEdgeCode),
    .evt_valid            (evt_valid),
    .evt_ready            (evt_ready),
    .evt_id               (evt_id),
    .evt_edge             (evt_edge),
    .overrun              (overrun),
`ifdef HIT_OVERRUN_CNT_EN
    .overrun_cnt          (overrun_cnt),
`endif
    .frame_busy           (frame_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] edg, input logic busy, input logic ovr);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      chk({tag, ".id"}, 32'(evt_id), 32'(id));
      chk({tag, ".edge"}, 32'(evt_edge), 32'(edg));
    end
    chk({tag, ".busy"}, 32'(frame_busy), 32'(busy));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pixel cycle, optionally the frame boundary; inputs return to idle afterwards.
  task automatic pix(input logic sof, input logic player, input logic [3:0] req,
                     input logic [15:0] codes);
    startOfFrame         = sof;
    playerDrawingRequest = player;
    objDrawingRequest    = req;
    objHitEdgeCode       = codes;
    step();
    startOfFrame         = 1'b0;
    playerDrawingRequest = 1'b0;
    objDrawingRequest    = '0;
    objHitEdgeCode       = '0;
  endtask

  initial begin
    reset = 1'b1;
    startOfFrame = 1'b0;
    playerDrawingRequest = 1'b0;
    objDrawingRequest = '0;
    objHitEdgeCode = '0;
    evt_ready = 1'b0;
    step();
    step();
    check_out("rst", 0, 0, 0, 0, 0);
    chk("rst.id", 32'(evt_id), 0);
    chk("rst.edge", 32'(evt_edge), 0);
`ifdef HIT_OVERRUN_CNT_EN
    chk("rst.cnt", 32'(overrun_cnt), 0);
`endif
    reset = 1'b0;

    // Three overlaps on obj 2; non-player and non-object pixels must not count.
    evt_ready = 1'b1;
    pix(0, 1, 4'b0100, 16'h0100);
    pix(0, 0, 4'b0010, 16'h0020);
    pix(0, 1, 4'b0100, 16'h0400);
    pix(0, 1, 4'b0000, 16'hffff);
    pix(0, 1, 4'b0100, 16'h0100);
    check_out("t1_pre", 0, 0, 0, 0, 0);
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t1_evt", 1, 2, 4'b0101, 1, 0);
    step();
    check_out("t1_done", 0, 0, 0, 0, 0);

    // Obj 3 and obj 0, ready high: back-to-back in index order.
    pix(0, 1, 4'b1000, 16'h8000);
    pix(0, 1, 4'b0001, 16'h0002);
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t2_e0", 1, 0, 4'b0010, 1, 0);
    step();
    check_out("t2_e3", 1, 3, 4'b1000, 1, 0);
    step();
    check_out("t2_done", 0, 0, 0, 0, 0);

    // Same frame with ready low for five cycles: output held stable.
    evt_ready = 1'b0;
    pix(0, 1, 4'b1000, 16'h8000);
    pix(0, 1, 4'b0001, 16'h0002);
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t3_hold0", 1, 0, 4'b0010, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("t3_hold", 1, 0, 4'b0010, 1, 0);
    end
    evt_ready = 1'b1;
    step();
    check_out("t3_e3", 1, 3, 4'b1000, 1, 0);
    step();
    check_out("t3_done", 0, 0, 0, 0, 0);

    // Two events pending, obj 1 hit meanwhile, next boundary discards them.
    evt_ready = 1'b0;
    pix(0, 1, 4'b1000, 16'h8000);
    pix(0, 1, 4'b0001, 16'h0002);
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t4_pend", 1, 0, 4'b0010, 1, 0);
    pix(0, 1, 4'b0010, 16'h0020);
    check_out("t4_pend2", 1, 0, 4'b0010, 1, 0);
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t4_ovr", 1, 1, 4'b0010, 1, 1);
`ifdef HIT_OVERRUN_CNT_EN
    chk("t4_cnt", 32'(overrun_cnt), 2);
`endif
    evt_ready = 1'b1;
    step();
    check_out("t4_done", 0, 0, 0, 0, 1);

    // Hit on the boundary pixel belongs to the next frame; empty snapshot yields nothing.
    pix(1, 1, 4'b0010, 16'h0040);
    check_out("t5_empty", 0, 0, 0, 0, 1);
    step();
    check_out("t5_idle", 0, 0, 0, 0, 1);
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t5_evt", 1, 1, 4'b0100, 1, 1);
    step();
    check_out("t5_done", 0, 0, 0, 0, 1);
`ifdef HIT_OVERRUN_CNT_EN
    chk("t5_cnt", 32'(overrun_cnt), 2);
`endif

    // Reset mid-REPORT with accumulated hits: all discarded, overrun cleared, not set.
    evt_ready = 1'b0;
    pix(0, 1, 4'b0001, 16'h0001);
    pix(0, 1, 4'b0100, 16'h0200);
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t6_pend", 1, 0, 4'b0001, 1, 1);
    pix(0, 1, 4'b1000, 16'h8000);
    reset = 1'b1;
    step();
    check_out("t6_rst", 0, 0, 0, 0, 0);
    chk("t6_rst.id", 32'(evt_id), 0);
    chk("t6_rst.edge", 32'(evt_edge), 0);
`ifdef HIT_OVERRUN_CNT_EN
    chk("t6_cnt", 32'(overrun_cnt), 0);
`endif
    reset = 1'b0;
    step();
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t6_empty", 0, 0, 0, 0, 0);
    step();
    check_out("t6_empty2", 0, 0, 0, 0, 0);

    // Handshake on the boundary cycle still overruns when another event remains.
    pix(0, 1, 4'b0001, 16'h0001);
    pix(0, 1, 4'b1000, 16'h8000);
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t7_pend", 1, 0, 4'b0001, 1, 0);
    evt_ready = 1'b1;
    pix(1, 0, 4'b0000, 16'h0000);
    check_out("t7_ovr", 0, 0, 0, 0, 1);
`ifdef HIT_OVERRUN_CNT_EN
    chk("t7_cnt", 32'(overrun_cnt), 1);
`endif
    step();
    check_out("t7_idle", 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
